// File: rtl/ex_muldiv_stage_pkg.sv
// Shared encodings for decode, ID/EX and the execute stage.
// Op classes, ALU/MULDIV functions, FSM states and the EX/MEM bundle.
package ex_muldiv_stage_pkg;

    localparam int XLEN     = 32;
    localparam int MD_STEPS = 32;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_ALU    = 3'd1,
        OP_ALUI   = 3'd2,
        OP_MULDIV = 3'd3,
        OP_LUI    = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } alu_fun_e;

    typedef enum logic [2:0] {
        MD_MUL   = 3'd0,
        MD_MULHU = 3'd1,
        MD_DIVU  = 3'd2,
        MD_REMU  = 3'd3
    } md_fun_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] wdata;
        logic            we;
        logic            rec;
    } ex_mem_t;

    function automatic logic [XLEN-1:0] alu_exec(
        input logic [2:0]      fun,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [XLEN-1:0] r;
        logic            lt;
        lt = $signed(a) < $signed(b);
        r  = '0;
        unique case (1'b1)
            (fun == ALU_ADD): r = a + b;
            (fun == ALU_SUB): r = a - b;
            (fun == ALU_AND): r = a & b;
            (fun == ALU_OR):  r = a | b;
            (fun == ALU_XOR): r = a ^ b;
            (fun == ALU_SLL): r = a << b[4:0];
            (fun == ALU_SRL): r = a >> b[4:0];
            (fun == ALU_SLT): r = {{(XLEN-1){1'b0}}, lt};
            default:          r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ex_muldiv_stage_md_iter_unit.sv
// Iterative unsigned multiplier / restoring divider, one step per cycle.
// hi/lo hold product or remainder/quotient; result is taken from the final step.
module md_iter_unit #(
    parameter int XLEN     = 32,
    parameter int MD_STEPS = 32
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            start_in,
    input  logic [2:0]      fun_in,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    output logic            last_out,
    output logic [XLEN-1:0] result_out
);
    import ex_muldiv_stage_pkg::*;

    localparam int CW = $clog2(MD_STEPS);

    logic            busy_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      fun_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] opb_q;
    logic [XLEN-1:0] hi_d;
    logic [XLEN-1:0] lo_d;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shl;
    logic            is_div;
    logic            ge;

    assign is_div = (fun_q == MD_DIVU) || (fun_q == MD_REMU);
    assign last_out = busy_q && (cnt_q == CW'(MD_STEPS - 1));

    always_comb begin
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        shl  = {hi_q, lo_q[XLEN-1]};
        ge   = shl >= {1'b0, opb_q};
        hi_d = hi_q;
        lo_d = lo_q;
        if (is_div) begin
            // a zero divisor always "fits", yielding all-ones and rem = dividend
            lo_d = {lo_q[XLEN-2:0], ge};
            hi_d = ge ? (shl[XLEN-1:0] - opb_q) : shl[XLEN-1:0];
        end else begin
            {hi_d, lo_d} = {sum, lo_q[XLEN-1:1]};
        end
    end

    always_comb begin
        result_out = '0;
        unique case (1'b1)
            (fun_q == MD_MUL):   result_out = lo_d;
            (fun_q == MD_MULHU): result_out = hi_d;
            (fun_q == MD_DIVU):  result_out = lo_d;
            (fun_q == MD_REMU):  result_out = hi_d;
            default:             result_out = '0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            fun_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opb_q  <= '0;
        end else if (start_in) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            fun_q  <= fun_in;
            hi_q   <= '0;
            lo_q   <= a_in;
            opb_q  <= b_in;
        end else if (busy_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 1'b1;
            if (last_out) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_muldiv_stage.sv
// Execute stage: 1-cycle ALU plus iterative mul/div with upstream stall.
// Define EX_FAST_MUL_EN for single-cycle MUL/MULHU via a combinational multiply.
module ex_muldiv_stage #(
    parameter int XLEN     = 32,
    parameter int MD_STEPS = 32
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic [2:0]      op_in,
    input  logic [2:0]      fun_in,
    input  logic [XLEN-1:0] rs1_in,
    input  logic [XLEN-1:0] rs2_in,
    input  logic [4:0]      rd_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic            rec_in,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] wdata_out,
    output logic            we_out,
    output logic            rec_out,
    output logic            stall_out
);
    import ex_muldiv_stage_pkg::*;

    state_e          state_q;
    state_e          state_d;
    ex_mem_t         out_q;
    ex_mem_t         out_d;
    logic [4:0]      md_rd_q;
    logic            is_alu;
    logic            is_md;
    logic            is_fast;
    logic            md_start;
    logic            md_last;
    logic [XLEN-1:0] md_res;
    logic [XLEN-1:0] alu_res;

    assign is_alu = rec_in && ((op_in == OP_ALU) ||
                               (op_in == OP_ALUI) ||
                               (op_in == OP_LUI));

`ifdef EX_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, rs1_in} * {{XLEN{1'b0}}, rs2_in};
    assign is_fast = rec_in && (op_in == OP_MULDIV) &&
                     ((fun_in == MD_MUL) || (fun_in == MD_MULHU));
`else
    assign is_fast = 1'b0;
`endif

    assign is_md    = rec_in && (op_in == OP_MULDIV) && !is_fast;
    assign md_start = (state_q == S_IDLE) && is_md;

    md_iter_unit #(
        .XLEN     (XLEN),
        .MD_STEPS (MD_STEPS)
    ) u_md (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .start_in   (md_start),
        .fun_in     (fun_in),
        .a_in       (rs1_in),
        .b_in       (rs2_in),
        .last_out   (md_last),
        .result_out (md_res)
    );

    always_comb begin
        alu_res = '0;
        unique case (1'b1)
            (op_in == OP_ALU):  alu_res = alu_exec(fun_in, rs1_in, rs2_in);
            (op_in == OP_ALUI): alu_res = alu_exec(fun_in, rs1_in, imm_in);
            (op_in == OP_LUI):  alu_res = imm_in;
`ifdef EX_FAST_MUL_EN
            is_fast: alu_res = (fun_in == MD_MUL) ? fast_prod[XLEN-1:0]
                                                  : fast_prod[2*XLEN-1:XLEN];
`endif
            default:            alu_res = '0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            md_rd_q <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            if (md_start) begin
                md_rd_q <= rd_in;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (md_start) state_d = S_BUSY;
            S_BUSY:  if (md_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // final busy cycle drops stall so upstream advances with the result
    always_comb begin
        out_d     = '0;
        stall_out = 1'b0;
        if (state_q == S_BUSY) begin
            stall_out = !md_last;
            if (md_last) begin
                out_d.rd    = md_rd_q;
                out_d.wdata = md_res;
                out_d.we    = (md_rd_q != 5'd0);
                out_d.rec   = 1'b1;
            end
        end else begin
            stall_out = md_start;
            if (is_alu || is_fast) begin
                out_d.rd    = rd_in;
                out_d.wdata = alu_res;
                out_d.we    = (rd_in != 5'd0);
                out_d.rec   = 1'b1;
            end
        end
    end

    assign rd_out    = out_q.rd;
    assign wdata_out = out_q.wdata;
    assign we_out    = out_q.we;
    assign rec_out   = out_q.rec;

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Scoreboard bench for ex_muldiv_stage: random bundles vs arithmetic model.
// Upstream register holds its bundle while stall_out is high.
module tb_ex_muldiv_stage;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [2:0]  op_in;
    logic [2:0]  fun_in;
    logic [31:0] rs1_in;
    logic [31:0] rs2_in;
    logic [4:0]  rd_in;
    logic [31:0] imm_in;
    logic        rec_in;
    logic [4:0]  rd_out;
    logic [31:0] wdata_out;
    logic        we_out;
    logic        rec_out;
    logic        stall_out;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  fun;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        rec;
    } bundle_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        we;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    ex_muldiv_stage dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .op_in     (op_in),
        .fun_in    (fun_in),
        .rs1_in    (rs1_in),
        .rs2_in    (rs2_in),
        .rd_in     (rd_in),
        .imm_in    (imm_in),
        .rec_in    (rec_in),
        .rd_out    (rd_out),
        .wdata_out (wdata_out),
        .we_out    (we_out),
        .rec_out   (rec_out),
        .stall_out (stall_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input bundle_t b);
        logic [31:0] a;
        logic [31:0] y;
        logic [63:0] p;
        a = b.rs1;
        y = (b.op == 3'd2) ? b.imm : b.rs2;
        p = {32'd0, b.rs1} * {32'd0, b.rs2};
        if (b.op == 3'd4) return b.imm;
        if (b.op == 3'd3) begin
            case (b.fun)
                3'd0: return p[31:0];
                3'd1: return p[63:32];
                3'd2: return (b.rs2 == 0) ? 32'hFFFF_FFFF : b.rs1 / b.rs2;
                3'd3: return (b.rs2 == 0) ? b.rs1 : b.rs1 % b.rs2;
                default: return 32'd0;
            endcase
        end
        case (b.fun)
            3'd0: return a + y;
            3'd1: return a - y;
            3'd2: return a & y;
            3'd3: return a | y;
            3'd4: return a ^ y;
            3'd5: return a << y[4:0];
            3'd6: return a >> y[4:0];
            default: return ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    function automatic bit produces(input bundle_t b);
        return b.rec && (b.op >= 3'd1) && (b.op <= 3'd4);
    endfunction

    function automatic int exp_cycles(input bundle_t b);
        if (!(b.rec && b.op == 3'd3)) return 1;
`ifdef EX_FAST_MUL_EN
        if (b.fun < 3'd2) return 1;
`endif
        return 33;
    endfunction

    task automatic drive(input bundle_t b);
        op_in  = b.op;
        fun_in = b.fun;
        rs1_in = b.rs1;
        rs2_in = b.rs2;
        rd_in  = b.rd;
        imm_in = b.imm;
        rec_in = b.rec;
    endtask

    function automatic bundle_t mk(input int op, input int fun,
                                   input logic [31:0] r1, input logic [31:0] r2,
                                   input logic [31:0] im, input int rd);
        bundle_t b;
        b.op  = 3'(op);
        b.fun = 3'(fun);
        b.rs1 = r1;
        b.rs2 = r2;
        b.imm = im;
        b.rd  = 5'(rd);
        b.rec = 1'b1;
        return b;
    endfunction

    // present one bundle until the stage accepts it (stall low at an edge)
    task automatic run(input bundle_t b, input bit use_lit,
                       input logic [31:0] lit);
        int   cyc;
        bit   s;
        exp_t e;
        drive(b);
        cyc = 0;
        do begin
            @(negedge clk_in);
            s = stall_out;
            @(posedge clk_in);
            #1;
            cyc++;
        end while (s && cyc < 200);
        chk("latency_cycles", 32'(cyc), 32'(exp_cycles(b)));
        if (produces(b)) begin
            e.rd    = b.rd;
            e.wdata = use_lit ? lit : ref_model(b);
            e.we    = (b.rd != 5'd0);
            sb.push_back(e);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (!rst_in && rec_out) begin
                if (sb.size() == 0) begin
                    chk("spurious_result", 32'(rec_out), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rd_out", 32'(rd_out), 32'(e.rd));
                    chk("wdata_out", wdata_out, e.wdata);
                    chk("we_out", 32'(we_out), 32'(e.we));
                end
            end
        end
    endtask

    task automatic idle(input int n);
        bundle_t b;
        b = mk(0, 0, 0, 0, 0, 0);
        b.rec = 1'b0;
        drive(b);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    initial begin
        bundle_t b;
        int      sel;
        rst_in = 1'b1;
        idle(0);
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_rd", 32'(rd_out), 32'd0);
        chk("rst_wdata", wdata_out, 32'd0);
        chk("rst_we", 32'(we_out), 32'd0);
        chk("rst_rec", 32'(rec_out), 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        run(mk(1, 1, 5, 7, 0, 3), 1'b1, 32'hFFFF_FFFE);
        run(mk(3, 0, 32'h10000, 32'h10001, 0, 4), 1'b1, 32'h0001_0000);
        run(mk(3, 1, 32'h10000, 32'h10001, 0, 4), 1'b1, 32'h0000_0001);
        run(mk(3, 2, 100, 0, 0, 6), 1'b1, 32'hFFFF_FFFF);
        run(mk(3, 3, 100, 0, 0, 6), 1'b1, 32'd100);
        run(mk(3, 2, 100, 7, 0, 7), 1'b1, 32'd14);
        run(mk(2, 0, 1, 0, 2, 5), 1'b1, 32'd3);
        run(mk(1, 0, 9, 4, 0, 0), 1'b1, 32'd13);
        run(mk(4, 0, 0, 0, 32'hABCD_E000, 8), 1'b1, 32'hABCD_E000);
        run(mk(3, 5, 123, 45, 0, 9), 1'b1, 32'd0);
        idle(3);

        b = mk(3, 2, 100, 7, 0, 9);
        drive(b);
        @(posedge clk_in);
        repeat (10) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        idle(1);
        rst_in = 1'b0;
        repeat (3) begin
            @(negedge clk_in);
            chk("post_rst_rec", 32'(rec_out), 32'd0);
            chk("post_rst_stall", 32'(stall_out), 32'd0);
        end
        @(posedge clk_in);
        #1;
        run(mk(1, 4, 32'hF0F0_0000, 32'h0FF0_00FF, 0, 11), 1'b1,
            32'hFF00_00FF);

        for (int i = 0; i < 150; i++) begin
            sel   = int'($urandom_range(0, 9));
            b.op  = (sel < 3) ? 3'd3 : 3'($urandom_range(0, 7));
            b.fun = 3'($urandom_range(0, 7));
            if (b.op == 3'd3 && $urandom_range(0, 3) != 0)
                b.fun = 3'($urandom_range(0, 3));
            b.rs1 = $urandom;
            sel   = int'($urandom_range(0, 3));
            b.rs2 = (sel == 0) ? 32'd0 :
                    (sel == 1) ? 32'($urandom_range(1, 15)) : $urandom;
            b.imm = $urandom;
            b.rd  = 5'($urandom_range(0, 31));
            b.rec = ($urandom_range(0, 9) != 0);
            run(b, 1'b0, 32'd0);
        end

        idle(5);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
